cordic_ctrl: RTL

CORDIC_CTRL -- requirements
Module: cordic_ctrl

---
 rtl/cordic_pkg.sv | 21 ++
 rtl/cordic_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC control slice.
// Holds the controller state encoding and the default configuration
// constants used by the sequencer and the arctangent ROM beside it.
package cordic_pkg;

    // Default number of micro-rotations per operation.
    localparam int CORDIC_N_ITER = 16;

    // Default address width of the arctangent ROM.
    localparam int CORDIC_ROM_AW = 10;

    // Controller states: wait for a request, capture operands,
    // run the micro-rotations, then present the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_OUT  = 2'd3
    } cordic_state_e;

endpackage : cordic_pkg

// File: rtl/cordic_ctrl.sv
// CORDIC iteration sequencer.
// Steps an external datapath through LOAD, N_ITER micro-rotations and a
// result hand-off, and drives the address of a synchronous-read arctangent
// ROM one entry ahead of the iteration that consumes it.
// Optional feature: define CORDIC_CTRL_ABORT_EN to add the abort input,
// which cancels an operation in flight and returns the sequencer to IDLE.
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER = CORDIC_N_ITER,
    parameter int AW     = CORDIC_ROM_AW,
    parameter int BASE   = 0,
    localparam int KW    = $clog2(N_ITER)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    output logic          load,
    output logic [AW-1:0] rom_addr,
    output logic          iter_en,
    output logic [KW-1:0] iter_idx,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef CORDIC_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy
);

    // ROM address used while iteration k runs: the entry for k+1 is
    // fetched so it arrives in time, clamped at the last table entry.
    function automatic logic [AW-1:0] iter_addr(input logic [KW-1:0] k);
        logic [31:0] step;
        step = {{(32-KW){1'b0}}, k} + 32'd1;
        if (step > 32'(N_ITER - 1)) begin
            step = 32'(N_ITER - 1);
        end else begin
            step = step;
        end
        return AW'(32'(BASE) + step);
    endfunction

    cordic_state_e state_r;
    cordic_state_e state_nxt_s;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_nxt_s;
    logic          abort_s;

    logic          ready_nxt_s;
    logic          load_nxt_s;
    logic          iter_en_nxt_s;
    logic          out_valid_nxt_s;
    logic          busy_nxt_s;
    logic [AW-1:0] rom_addr_nxt_s;

    logic          ready_r;
    logic          load_r;
    logic          iter_en_r;
    logic          out_valid_r;
    logic          busy_r;
    logic [AW-1:0] rom_addr_r;

`ifdef CORDIC_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state and iteration-counter logic; abort beats every other exit.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        unique case (state_r)
            ST_IDLE: begin
                k_nxt_s = {KW{1'b0}};
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                k_nxt_s = {KW{1'b0}};
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_ITER: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                    k_nxt_s     = {KW{1'b0}};
                end else if (k_r == KW'(N_ITER - 1)) begin
                    state_nxt_s = ST_OUT;
                    k_nxt_s     = {KW{1'b0}};
                end else begin
                    state_nxt_s = ST_ITER;
                    k_nxt_s     = k_r + {{(KW-1){1'b0}}, 1'b1};
                end
            end
            ST_OUT: begin
                k_nxt_s = {KW{1'b0}};
                if (abort_s || out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                k_nxt_s     = {KW{1'b0}};
            end
        endcase
    end

    // Output values for the upcoming state, so every output leaves a flop.
    always_comb begin
        ready_nxt_s     = 1'b0;
        load_nxt_s      = 1'b0;
        iter_en_nxt_s   = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b1;
        rom_addr_nxt_s  = AW'(BASE);
        unique case (state_nxt_s)
            ST_IDLE: begin
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b0;
            end
            ST_LOAD: begin
                load_nxt_s = 1'b1;
            end
            ST_ITER: begin
                iter_en_nxt_s  = 1'b1;
                rom_addr_nxt_s = iter_addr(k_nxt_s);
            end
            ST_OUT: begin
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset drops straight to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            k_r         <= {KW{1'b0}};
            ready_r     <= 1'b1;
            load_r      <= 1'b0;
            iter_en_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            rom_addr_r  <= AW'(BASE);
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            ready_r     <= ready_nxt_s;
            load_r      <= load_nxt_s;
            iter_en_r   <= iter_en_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            rom_addr_r  <= rom_addr_nxt_s;
        end
    end

    // The counter is zero outside ITER, so it doubles as the shift index.
    assign iter_idx  = k_r;
    assign ready     = ready_r;
    assign load      = load_r;
    assign iter_en   = iter_en_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign rom_addr  = rom_addr_r;

endmodule : cordic_ctrl
